mandala_sequencer: RTL and testbench
====================================

MANDALA_SEQUENCER -- requirements
Module: mandala_sequencer

Interface
REQ-001 SHALL have parameter STEP, default 1: pattern_phase increment per frame after reset, range 0..15.
REQ-002 SHALL have parameter SWEEP_FRAMES, default 30: frames per layer rotation in SWEEP, range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock, pixel clock domain.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port vsync, input, 1: active-high vertical sync from the sync generator.
REQ-006 SHALL have port cmd_valid, input, 1: command offered.
REQ-007 SHALL have port cmd_op, input, 2: 0 SET_MODE, 1 SET_LAYERS, 2 SET_SPEED, 3 SET_PHASE.
REQ-008 SHALL have port cmd_data, input, 8: command operand.
REQ-009 SHALL have port cmd_ready, output, 1: high when a command can be accepted.
REQ-010 SHALL have port pattern_phase, output, 8: angle offset to the mandala datapath.
REQ-011 SHALL have port color_base, output, 6: base colour {R,G,B} to the datapath.
REQ-012 SHALL have port layer_en, output, 8: per-ring enable; bit0 is the innermost ring.
REQ-013 SHALL have port mode, output, 2: current state, 0 RUN, 1 PAUSE, 2 SWEEP.
REQ-014 SHALL have port frame_tick, output, 1: one-cycle pulse per frame update.

Function
REQ-015 SHALL register vsync into vs_q; frame edge = vsync & ~vs_q.
REQ-016 SHALL update all outputs and assert frame_tick for exactly one cycle, registered, on the clock edge after the frame edge is detected.
REQ-017 SHALL change pattern_phase, color_base, layer_en and mode only on frame_tick cycles; mid-frame they are constant.
- This guarantees the datapath never sees a torn frame.
REQ-018 SHALL accept a command when cmd_valid & cmd_ready, store it as a single pending entry, and drop cmd_ready the following cycle.
REQ-019 SHALL apply the pending command at the next frame update and raise cmd_ready in the cycle after that update.
REQ-020 SHALL treat a command accepted in the same cycle as a frame edge as pending and apply it at the following frame update.
REQ-021 SHALL, at a frame update, apply the pending command first, then advance the state using the post-command values.
REQ-022 SET_MODE SHALL load mode from cmd_data[1:0].
- Value 3 is ignored: mode is unchanged and the command is still consumed.
REQ-023 SET_LAYERS SHALL load layer_en <= cmd_data.
- SET_SPEED SHALL load speed <= cmd_data[3:0]; speed 0 freezes the phase.
- SET_PHASE SHALL load pattern_phase <= cmd_data; that frame's phase advance is skipped.
REQ-024 RUN SHALL, each frame: pattern_phase += speed mod 256; color_base += 1 mod 64.
REQ-025 PAUSE SHALL hold pattern_phase and color_base.
- A SET_PHASE or SET_LAYERS applied in PAUSE takes effect but nothing advances.
REQ-026 SWEEP SHALL advance as in RUN and also count frames 0..SWEEP_FRAMES-1.
- On wrap, layer_en rotates left by 1 (bit7 -> bit0).
- If layer_en == 0 at the rotation point, it SHALL load 8'h01 instead.
REQ-027 The sweep counter SHALL clear to 0 on every entry into SWEEP and hold outside SWEEP.
REQ-028 All arithmetic SHALL wrap modulo field width, with no saturation.

Reset
REQ-029 On rst_n low, outputs SHALL asynchronously go to:
- pattern_phase 0, color_base 0, layer_en 8'hFF, mode 0 (RUN)
- frame_tick 0, cmd_ready 1
- speed STEP, vs_q 0, sweep counter 0
REQ-030 Reset mid-operation SHALL discard any pending command; the first update after reset requires a new vsync rising edge.

Configuration
REQ-031 Macro MANDALA_SEQ_SWEEP_EN defined: SWEEP state and its counter SHALL be built as in REQ-026/027.
REQ-032 Macro MANDALA_SEQ_SWEEP_EN undefined: no sweep logic SHALL be built.
- SET_MODE with value 2 SHALL load RUN (mode reads 0).

Verification
REQ-033 Reset release, 3 vsync pulses, no commands -> 3 single-cycle frame_tick pulses; pattern_phase 3; color_base 3; layer_en FF; cmd_ready 1.
REQ-034 SET_SPEED 5, then SET_PHASE 8'hFE, each accepted mid-frame:
- cmd_ready low until the update after each acceptance.
- pattern_phase sequence: 5 ... then FE, then 03 at the next update (wrap).
REQ-035 SET_MODE 1 (PAUSE) over 4 frames -> phase and colour constant, frame_tick still pulses; SET_MODE 0 resumes from the held values.
REQ-036 cmd_valid asserted in the exact cycle of the frame edge with SET_LAYERS 8'h0F -> layer_en FF after that update, 0F after the next.
REQ-037 SWEEP_EN defined, SWEEP_FRAMES=2, SET_LAYERS 00 then SET_MODE 2 -> layer_en 01 after 2 frames, 02 after 4, 04 after 6.
- Undefined: mode reads 0 and layer_en stays 00.
REQ-038 rst_n pulsed low while a command is pending -> all outputs take reset values immediately; the pending command is never applied.

Source files
------------

// File: rtl/mandala_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mandala_sequencer
//  Description : Frame-synchronous control sequencer for the mandala pattern
//                datapath. It detects the vsync rising edge and, once per
//                frame, applies at most one pending host command. It then
//                advances the pattern phase, base colour and (in SWEEP) the
//                ring-enable rotation. All datapath-facing outputs change only
//                on frame_tick cycles, so a frame is never torn.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    STEP          : speed loaded at reset (phase increment per frame), 0..15
//    SWEEP_FRAMES  : frames per ring rotation in SWEEP, 1..255
//  Configuration macro
//    MANDALA_SEQ_SWEEP_EN : builds the SWEEP state and its frame counter.
//                           When undefined, SET_MODE 2 selects RUN.
//  Ports
//    clk           in   pixel clock
//    rst_n         in   asynchronous active-low reset
//    vsync         in   active-high vertical sync
//    cmd_valid     in   command offered
//    cmd_op   [1:0] in  0 SET_MODE, 1 SET_LAYERS, 2 SET_SPEED, 3 SET_PHASE
//    cmd_data [7:0] in  command operand
//    cmd_ready     out  a command can be accepted (single pending slot free)
//    pattern_phase[7:0] out angle offset to the datapath
//    color_base   [5:0] out base colour {R,G,B}
//    layer_en     [7:0] out per-ring enable, bit0 innermost
//    mode         [1:0] out 0 RUN, 1 PAUSE, 2 SWEEP
//    frame_tick    out  one-cycle pulse on each frame update
// ============================================================================
module mandala_sequencer #(
    parameter int STEP         = 1,
    parameter int SWEEP_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic [7:0] pattern_phase,
    output logic [5:0] color_base,
    output logic [7:0] layer_en,
    output logic [1:0] mode,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    localparam logic [1:0] c_op_mode   = 2'd0;
    localparam logic [1:0] c_op_layers = 2'd1;
    localparam logic [1:0] c_op_speed  = 2'd2;

    // Out-of-range parameters are rejected at elaboration time.
    if (STEP < 0 || STEP > 15) begin : g_bad_step
        $error("mandala_sequencer: STEP must be 0..15");
    end
    if (SWEEP_FRAMES < 1 || SWEEP_FRAMES > 255) begin : g_bad_sweep_frames
        $error("mandala_sequencer: SWEEP_FRAMES must be 1..255");
    end

    state_t     r_state;
    logic       r_vs_q;
    logic [3:0] r_speed;
    logic       r_pend_valid;
    logic [1:0] r_pend_op;
    logic [7:0] r_pend_data;

    logic       w_frame_edge;
    state_t     w_state_post;
    logic [7:0] w_layer_post;
    logic [3:0] w_speed_post;
    logic [7:0] w_phase_post;
    logic       w_phase_loaded;
    logic [7:0] w_phase_nxt;
    logic [5:0] w_color_nxt;
    logic [7:0] w_layer_nxt;

`ifdef MANDALA_SEQ_SWEEP_EN
    localparam logic [7:0] c_sweep_last = 8'(SWEEP_FRAMES - 1);
    logic [7:0] r_sweep_cnt;
    logic [7:0] w_sweep_cnt_nxt;
`endif

    assign w_frame_edge = vsync & ~r_vs_q;
    assign mode         = r_state;

    // Frame update: the pending command is applied first, and the advance
    // step below works on the post-command values.
    always_comb begin
        w_state_post   = r_state;
        w_layer_post   = layer_en;
        w_speed_post   = r_speed;
        w_phase_post   = pattern_phase;
        w_phase_loaded = 1'b0;
        if (r_pend_valid) begin
            case (r_pend_op)
                c_op_mode: begin
                    case (r_pend_data[1:0])
                        2'd0:    w_state_post = ST_RUN;
                        2'd1:    w_state_post = ST_PAUSE;
`ifdef MANDALA_SEQ_SWEEP_EN
                        2'd2:    w_state_post = ST_SWEEP;
`else
                        2'd2:    w_state_post = ST_RUN;
`endif
                        default: w_state_post = r_state;  // value 3: consumed, no effect
                    endcase
                end
                c_op_layers: w_layer_post = r_pend_data;
                c_op_speed:  w_speed_post = r_pend_data[3:0];
                default: begin
                    // SET_PHASE replaces this frame's phase advance.
                    w_phase_post   = r_pend_data;
                    w_phase_loaded = 1'b1;
                end
            endcase
        end

        w_phase_nxt = w_phase_post;
        w_color_nxt = color_base;
        w_layer_nxt = w_layer_post;
        if (w_state_post != ST_PAUSE) begin
            if (!w_phase_loaded) begin
                w_phase_nxt = w_phase_post + {4'd0, w_speed_post};
            end
            w_color_nxt = color_base + 6'd1;
        end

`ifdef MANDALA_SEQ_SWEEP_EN
        w_sweep_cnt_nxt = r_sweep_cnt;
        if (w_state_post == ST_SWEEP) begin
            if (r_state != ST_SWEEP) begin
                // The entry frame only restarts the count.
                w_sweep_cnt_nxt = 8'd0;
            end else if (r_sweep_cnt == c_sweep_last) begin
                w_sweep_cnt_nxt = 8'd0;
                // An all-off ring mask would rotate forever as zero, so
                // reseed it with the innermost ring.
                w_layer_nxt = (w_layer_post == 8'h00) ? 8'h01
                                                      : {w_layer_post[6:0], w_layer_post[7]};
            end else begin
                w_sweep_cnt_nxt = r_sweep_cnt + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_vs_q        <= 1'b0;
            r_speed       <= 4'(STEP);
            r_pend_valid  <= 1'b0;
            r_pend_op     <= 2'd0;
            r_pend_data   <= 8'd0;
            cmd_ready     <= 1'b1;
            pattern_phase <= 8'd0;
            color_base    <= 6'd0;
            layer_en      <= 8'hFF;
            frame_tick    <= 1'b0;
`ifdef MANDALA_SEQ_SWEEP_EN
            r_sweep_cnt   <= 8'd0;
`endif
        end else begin
            r_vs_q     <= vsync;
            frame_tick <= w_frame_edge;

            if (w_frame_edge) begin
                r_state       <= w_state_post;
                r_speed       <= w_speed_post;
                pattern_phase <= w_phase_nxt;
                color_base    <= w_color_nxt;
                layer_en      <= w_layer_nxt;
`ifdef MANDALA_SEQ_SWEEP_EN
                r_sweep_cnt   <= w_sweep_cnt_nxt;
`endif
                if (r_pend_valid) begin
                    r_pend_valid <= 1'b0;
                    cmd_ready    <= 1'b1;
                end
            end

            // cmd_ready is low whenever the slot is occupied, so an accept
            // can never coincide with the update that consumes a command.
            // An accept on the frame-edge cycle waits for the next update.
            if (cmd_valid && cmd_ready) begin
                r_pend_valid <= 1'b1;
                r_pend_op    <= cmd_op;
                r_pend_data  <= cmd_data;
                cmd_ready    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mandala_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mandala_sequencer
//  Description : Directed self-checking bench for mandala_sequencer
//                (STEP=1, SWEEP_FRAMES=2). Expectations for the SWEEP scenario
//                follow the MANDALA_SEQ_SWEEP_EN build setting.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mandala_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ready;
    logic [7:0] pattern_phase;
    logic [5:0] color_base;
    logic [7:0] layer_en;
    logic [1:0] mode;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;
    int tick_tot = 0;

    mandala_sequencer #(
        .STEP         (1),
        .SWEEP_FRAMES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vsync         (vsync),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .pattern_phase (pattern_phase),
        .color_base    (color_base),
        .layer_en      (layer_en),
        .mode          (mode),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; vsync = 1'b0; cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One vsync pulse; counts frame_tick cycles seen in the frame window.
    task automatic frame();
        tick_cnt = 0;
        @(negedge clk);
        vsync = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) tick_cnt++;
            if (i == 1) vsync = 1'b0;
        end
        tick_tot += tick_cnt;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pattern_phase !== 8'h00) begin failures++; $display("FAIL reset_phase got=%h exp=00", pattern_phase); end
        checks++; if (color_base !== 6'h00) begin failures++; $display("FAIL reset_color got=%h exp=00", color_base); end
        checks++; if (layer_en !== 8'hFF) begin failures++; $display("FAIL reset_layer got=%h exp=ff", layer_en); end
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_free_run();
        do_reset();
        tick_tot = 0;
        repeat (3) frame();
        checks++; if (tick_tot != 3) begin failures++; $display("FAIL free_ticks got=%0d exp=3", tick_tot); end
        checks++; if (pattern_phase !== 8'h03) begin failures++; $display("FAIL free_phase got=%h exp=03", pattern_phase); end
        checks++; if (color_base !== 6'h03) begin failures++; $display("FAIL free_color got=%h exp=03", color_base); end
        checks++; if (layer_en !== 8'hFF) begin failures++; $display("FAIL free_layer got=%h exp=ff", layer_en); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL free_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_speed_phase();
        do_reset();
        send_cmd(2'd2, 8'h05);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL speed_ready_low got=%b exp=0", cmd_ready); end
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL speed_ready_hold got=%b exp=0", cmd_ready); end
        frame();
        checks++; if (pattern_phase !== 8'h05) begin failures++; $display("FAIL speed_phase1 got=%h exp=05", pattern_phase); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL speed_ready_back got=%b exp=1", cmd_ready); end
        frame();
        checks++; if (pattern_phase !== 8'h0A) begin failures++; $display("FAIL speed_phase2 got=%h exp=0a", pattern_phase); end
        send_cmd(2'd3, 8'hFE);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL phase_ready_low got=%b exp=0", cmd_ready); end
        frame();
        checks++; if (pattern_phase !== 8'hFE) begin failures++; $display("FAIL phase_load got=%h exp=fe", pattern_phase); end
        checks++; if (color_base !== 6'h03) begin failures++; $display("FAIL phase_color got=%h exp=03", color_base); end
        frame();
        checks++; if (pattern_phase !== 8'h03) begin failures++; $display("FAIL phase_wrap got=%h exp=03", pattern_phase); end
    endtask

    task automatic test_pause();
        do_reset();
        frame();
        send_cmd(2'd0, 8'h01);
        tick_tot = 0;
        repeat (4) frame();
        checks++; if (mode !== 2'd1) begin failures++; $display("FAIL pause_mode got=%0d exp=1", mode); end
        checks++; if (tick_tot != 4) begin failures++; $display("FAIL pause_ticks got=%0d exp=4", tick_tot); end
        checks++; if (pattern_phase !== 8'h01) begin failures++; $display("FAIL pause_phase got=%h exp=01", pattern_phase); end
        checks++; if (color_base !== 6'h01) begin failures++; $display("FAIL pause_color got=%h exp=01", color_base); end
        send_cmd(2'd0, 8'h03);
        frame();
        checks++; if (mode !== 2'd1) begin failures++; $display("FAIL mode3_ignored got=%0d exp=1", mode); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mode3_consumed got=%b exp=1", cmd_ready); end
        send_cmd(2'd0, 8'h00);
        frame();
        checks++; if (mode !== 2'd0) begin failures++; $display("FAIL resume_mode got=%0d exp=0", mode); end
        checks++; if (pattern_phase !== 8'h02) begin failures++; $display("FAIL resume_phase got=%h exp=02", pattern_phase); end
        checks++; if (color_base !== 6'h02) begin failures++; $display("FAIL resume_color got=%h exp=02", color_base); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        @(negedge clk);
        vsync = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 8'h0F;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL same_tick got=%b exp=1", frame_tick); end
        checks++; if (layer_en !== 8'hFF) begin failures++; $display("FAIL same_layer_first got=%h exp=ff", layer_en); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL same_ready got=%b exp=0", cmd_ready); end
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (layer_en !== 8'hFF) begin failures++; $display("FAIL same_layer_mid got=%h exp=ff", layer_en); end
        frame();
        checks++; if (layer_en !== 8'h0F) begin failures++; $display("FAIL same_layer_next got=%h exp=0f", layer_en); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL same_ready_back got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_sweep();
        logic [1:0] exp_mode;
        logic [7:0] exp_l2, exp_l4, exp_l6;
`ifdef MANDALA_SEQ_SWEEP_EN
        exp_mode = 2'd2; exp_l2 = 8'h01; exp_l4 = 8'h02; exp_l6 = 8'h04;
`else
        exp_mode = 2'd0; exp_l2 = 8'h00; exp_l4 = 8'h00; exp_l6 = 8'h00;
`endif
        do_reset();
        send_cmd(2'd1, 8'h00);
        frame();
        checks++; if (layer_en !== 8'h00) begin failures++; $display("FAIL sweep_layer_clear got=%h exp=00", layer_en); end
        send_cmd(2'd0, 8'h02);
        frame();
        checks++; if (mode !== exp_mode) begin failures++; $display("FAIL sweep_mode got=%0d exp=%0d", mode, exp_mode); end
        frame();
        checks++; if (layer_en !== 8'h00) begin failures++; $display("FAIL sweep_layer_f1 got=%h exp=00", layer_en); end
        frame();
        checks++; if (layer_en !== exp_l2) begin failures++; $display("FAIL sweep_layer_f2 got=%h exp=%h", layer_en, exp_l2); end
        repeat (2) frame();
        checks++; if (layer_en !== exp_l4) begin failures++; $display("FAIL sweep_layer_f4 got=%h exp=%h", layer_en, exp_l4); end
        repeat (2) frame();
        checks++; if (layer_en !== exp_l6) begin failures++; $display("FAIL sweep_layer_f6 got=%h exp=%h", layer_en, exp_l6); end
        checks++; if (pattern_phase !== 8'h08) begin failures++; $display("FAIL sweep_phase got=%h exp=08", pattern_phase); end
    endtask

    task automatic test_reset_pending();
        do_reset();
        frame();
        send_cmd(2'd3, 8'h55);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (pattern_phase !== 8'h00) begin failures++; $display("FAIL arst_phase got=%h exp=00", pattern_phase); end
        checks++; if (color_base !== 6'h00) begin failures++; $display("FAIL arst_color got=%h exp=00", color_base); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (pattern_phase !== 8'h00) begin failures++; $display("FAIL arst_no_update got=%h exp=00", pattern_phase); end
        frame();
        checks++; if (pattern_phase !== 8'h01) begin failures++; $display("FAIL arst_discard got=%h exp=01", pattern_phase); end
        checks++; if (tick_cnt != 1) begin failures++; $display("FAIL arst_tick got=%0d exp=1", tick_cnt); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_speed_phase();
        test_pause();
        test_same_cycle();
        test_sweep();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
